// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types, plus the queued predictor-update record and the update-controller state.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  prediction;
        logic  branch_result;
        word_t pc;
        word_t target;
        logic  direction;
    } pred_update_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DRAINED
    } pred_upd_state_t;

endpackage

// File: rtl/pred_update_fifo.sv
// DEPTH-entry FIFO of pred_update_t with full/empty/count; pointers wrap modulo DEPTH.
module pred_update_fifo
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       push,
    input  pred_update_t               wdata,
    input  logic                       pop,
    output pred_update_t               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    pred_update_t     mem_q [DEPTH];
    pred_update_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/predictor_update_ctrl.sv
// Queues resolved branch/jump outcomes and issues them to the predictor update port.
// Optional `define PRED_STATS_EN adds saturating update / mispredict counters.
module predictor_update_ctrl
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_prediction,
    input  logic              ex_branch_result,
    input  word_t             ex_pc,
    input  word_t             ex_target,
    input  logic              pred_busy,
    output logic              update_predictor,
    output logic              prediction,
    output logic              branch_result,
    output word_t             pc_to_update,
    output word_t             update_addr,
    output logic              direction,
    output logic              mispredict,
    input  logic              drain_req,
    output logic              drain_done
`ifdef PRED_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_updates,
    output logic [CNT_W-1:0]  stat_mispredicts
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    pred_upd_state_t state_q, state_d;
    pred_update_t    fifo_wdata, fifo_rdata, issue_q, issue_d;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count, count_next;
    logic            push, pop;
    logic            ex_ready_q, ex_ready_d;
    logic            update_q, update_d;
    logic            mispredict_q, mispredict_d;

    pred_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        push = ex_valid && ex_ready_q && (ex_is_branch || ex_is_jump) && !drain_req;
        pop  = ((state_q == ISSUE) || (state_q == DRAIN)) && !fifo_empty && !pred_busy;

        fifo_wdata.prediction    = ex_prediction;
        fifo_wdata.branch_result = ex_branch_result;
        fifo_wdata.pc            = ex_pc;
        fifo_wdata.target        = ex_target;
        fifo_wdata.direction     = (ex_target < ex_pc);

        count_next = fifo_count + CW'(push) - CW'(pop);

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (drain_req)  state_d = DRAINED;
                else if (push)  state_d = ISSUE;
            end
            ISSUE: begin
                if (drain_req)              state_d = DRAIN;
                else if (count_next == '0)  state_d = IDLE;
            end
            DRAIN: begin
                if (count_next == '0) state_d = DRAINED;
            end
            DRAINED: begin
                if (!drain_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered so ex_ready never depends on this cycle's pop, and reads 0 under reset.
        ex_ready_d = (count_next != CW'(DEPTH)) && ((state_d == IDLE) || (state_d == ISSUE));

        update_d     = pop;
        issue_d      = pop ? fifo_rdata : issue_q;
        mispredict_d = pop && (fifo_rdata.prediction != fifo_rdata.branch_result);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            ex_ready_q   <= 1'b0;
            update_q     <= 1'b0;
            mispredict_q <= 1'b0;
            issue_q      <= '0;
        end else begin
            state_q      <= state_d;
            ex_ready_q   <= ex_ready_d;
            update_q     <= update_d;
            mispredict_q <= mispredict_d;
            issue_q      <= issue_d;
        end
    end

    assign ex_ready         = ex_ready_q;
    assign update_predictor = update_q;
    assign mispredict       = mispredict_q;
    assign prediction       = issue_q.prediction;
    assign branch_result    = issue_q.branch_result;
    assign pc_to_update     = issue_q.pc;
    assign update_addr      = issue_q.target;
    assign direction        = issue_q.direction;
    assign drain_done       = (state_q == DRAINED);

`ifdef PRED_STATS_EN
    logic [CNT_W-1:0] stat_upd_q, stat_upd_d;
    logic [CNT_W-1:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (update_q && (stat_upd_q != '1))     stat_upd_d = stat_upd_q + CNT_W'(1);
        if (mispredict_q && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_updates     = stat_upd_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// Self-checking bench for predictor_update_ctrl: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_predictor_update_ctrl;

    localparam int DEPTH = 4;
`ifdef PRED_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 32;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0;
    logic        ex_prediction = 1'b0, ex_branch_result = 1'b0;
    logic [31:0] ex_pc = '0, ex_target = '0;
    logic        pred_busy = 1'b0, drain_req = 1'b0;
    logic        ex_ready, update_predictor, prediction, branch_result, direction, mispredict, drain_done;
    logic [31:0] pc_to_update, update_addr;
`ifdef PRED_STATS_EN
    logic [CNT_W-1:0] stat_updates, stat_mispredicts;
`endif

    predictor_update_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .ex_prediction    (ex_prediction),
        .ex_branch_result (ex_branch_result),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .pred_busy        (pred_busy),
        .update_predictor (update_predictor),
        .prediction       (prediction),
        .branch_result    (branch_result),
        .pc_to_update     (pc_to_update),
        .update_addr      (update_addr),
        .direction        (direction),
        .mispredict       (mispredict),
        .drain_req        (drain_req),
        .drain_done       (drain_done)
`ifdef PRED_STATS_EN
        ,
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of offered outcomes plus the drain mode.
    typedef struct {
        logic        pred;
        logic        res;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    int          mode;           // 0 normal, 1 draining, 2 drained
    logic        e_ready, e_upd, e_misp, e_pred, e_res, e_dir;
    logic [31:0] e_pc, e_tgt;
    int          e_su, e_sm;
    localparam int STAT_MAX = (CNT_W >= 31) ? 32'h7fffffff : ((1 << CNT_W) - 1);

    task automatic model_clear();
        mq.delete();
        mode = 0;
        e_ready = 0; e_upd = 0; e_misp = 0; e_pred = 0; e_res = 0; e_dir = 0;
        e_pc = '0; e_tgt = '0; e_su = 0; e_sm = 0;
    endtask

    task automatic model_step();
        int   sz0;
        logic acc, pp;
        ent_t ent;
        sz0 = mq.size();
        acc = e_ready && ex_valid && (ex_is_branch || ex_is_jump) && !drain_req;
        pp  = (sz0 > 0) && !pred_busy;
        if (e_upd  && e_su < STAT_MAX) e_su++;
        if (e_misp && e_sm < STAT_MAX) e_sm++;
        e_upd  = pp;
        e_misp = 1'b0;
        if (pp) begin
            ent    = mq.pop_front();
            e_pred = ent.pred; e_res = ent.res; e_pc = ent.pc; e_tgt = ent.tgt;
            e_dir  = (ent.tgt < ent.pc);
            e_misp = (ent.pred != ent.res);
        end
        if (acc) begin
            ent.pred = ex_prediction; ent.res = ex_branch_result;
            ent.pc = ex_pc; ent.tgt = ex_target;
            mq.push_back(ent);
        end
        case (mode)
            0: if (drain_req) mode = (sz0 == 0) ? 2 : 1;
            1: if (mq.size() == 0) mode = 2;
            default: if (!drain_req) mode = 0;
        endcase
        e_ready = (mq.size() < DEPTH) && (mode == 0);
    endtask

    task automatic check_all();
        check_eq("ex_ready", ex_ready, e_ready);
        check_eq("update_predictor", update_predictor, e_upd);
        check_eq("mispredict", mispredict, e_misp);
        check_eq("drain_done", drain_done, (mode == 2));
        if (e_upd) begin
            check_eq("pc_to_update", pc_to_update, e_pc);
            check_eq("update_addr", update_addr, e_tgt);
            check_eq("prediction", prediction, e_pred);
            check_eq("branch_result", branch_result, e_res);
            check_eq("direction", direction, e_dir);
        end
`ifdef PRED_STATS_EN
        check_eq("stat_updates", stat_updates, e_su);
        check_eq("stat_mispredicts", stat_mispredicts, e_sm);
`endif
    endtask

    task automatic drive(input logic v, input logic br, input logic jp, input logic pr, input logic rs,
                         input logic [31:0] pc, input logic [31:0] tg, input logic busy, input logic dr);
        ex_valid = v; ex_is_branch = br; ex_is_jump = jp; ex_prediction = pr; ex_branch_result = rs;
        ex_pc = pc; ex_target = tg; pred_busy = busy; drain_req = dr;
    endtask

    task automatic idle(input logic busy, input logic dr);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, busy, dr);
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        idle(0, 0);
        nRST = 1'b0;
        #2;
        model_clear();
        check_eq("rst_ex_ready", ex_ready, 0);
        check_eq("rst_update", update_predictor, 0);
        check_eq("rst_pc", pc_to_update, 0);
        check_eq("rst_addr", update_addr, 0);
        check_eq("rst_misp", mispredict, 0);
        check_eq("rst_done", drain_done, 0);
        @(negedge CLK);
        nRST = 1'b1;
        step();
        step();
    endtask

    initial begin
        int nup;
        logic dr;
        model_clear();
        do_reset();

        // 1: single backward mispredicted branch, latency 2
        drive(1, 1, 0, 1, 0, 32'h100, 32'h80, 0, 0);
        step();
        idle(0, 0);
        step();
        check_eq("t1_update", update_predictor, 1);
        check_eq("t1_direction", direction, 1);
        check_eq("t1_mispredict", mispredict, 1);
        step();
        check_eq("t1_single_cycle", update_predictor, 0);

        // 2: fill under pred_busy, 5th offer refused, then FIFO-order drain
        for (int i = 0; i < 5; i++) begin
            drive(1, i[0], !i[0], 1, 1, 32'h200 + 4 * i, 32'h300 + 4 * i, 1, 0);
            step();
            if (i == 3) check_eq("t2_ready_full", ex_ready, 0);
        end
        idle(0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t2_update", update_predictor, 1);
            check_eq("t2_order", pc_to_update, 32'h200 + 4 * i);
        end
        step();
        check_eq("t2_empty", update_predictor, 0);

        // 3: drain with two queued entries while a push is offered
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 0, 32'h400 + 4 * i, 32'h500, 1, 0);
            step();
        end
        drive(1, 1, 0, 0, 1, 32'h480, 32'h10, 0, 1);
        nup = 0;
        step();
        nup += update_predictor;
        idle(0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            nup += update_predictor;
        end
        check_eq("t3_updates", nup, 2);
        check_eq("t3_drain_done", drain_done, 1);
        check_eq("t3_ready_drained", ex_ready, 0);
        idle(0, 0);
        step();
        check_eq("t3_done_clears", drain_done, 0);
        step();

        // 4: steady push+pop at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 1, 1, 32'h600 + 4 * i, 32'h700, 1, 0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, i[1], i[0], 32'h800 + 4 * i, 32'h900 - 8 * i, 0, 0);
            step();
            check_eq("t4_ready", ex_ready, 1);
            check_eq("t4_update", update_predictor, 1);
        end
        idle(0, 0);
        for (int i = 0; i < 4; i++) step();

        // 5: reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 0, 32'hA00 + 4 * i, 32'h0, 1, 0);
            step();
        end
        do_reset();
        idle(0, 0);
        nup = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            nup += update_predictor;
        end
        check_eq("t5_no_update_after_reset", nup, 0);

`ifdef PRED_STATS_EN
        // 6: three updates, one mispredicted, then one more to saturate a 2-bit counter
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, (i == 1) ? 1'b0 : 1'b1, 32'hB00 + 4 * i, 32'hC00, 0, 0);
            step();
        end
        idle(0, 0);
        for (int i = 0; i < 4; i++) step();
        check_eq("t6_stat_updates", stat_updates, 3);
        check_eq("t6_stat_mispredicts", stat_mispredicts, 1);
        drive(1, 0, 1, 0, 0, 32'hD00, 32'hD80, 0, 0);
        step();
        idle(0, 0);
        for (int i = 0; i < 3; i++) step();
        check_eq("t6_stat_saturated", stat_updates, 3);
`endif

        // Random traffic
        dr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) dr = !dr;
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, $urandom_range(0, 9) < 3, dr);
            step();
        end
        idle(0, 0);
        for (int i = 0; i < 8; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
